// File: rtl/matrix_loader.sv
// matrix_loader: collects a stream of N*N A elements followed by N*N B
// elements (both row-major) and presents them as one packed A/B pair to a
// downstream multiplier. Framing errors (early or missing s_last) pulse err
// and discard the frame; after a missing last, beats are dropped until the
// next s_last resynchronises the stream.
//
// state   | meaning
// LOAD_A  | accepting A elements into slot idx
// LOAD_B  | accepting B elements into slot idx
// PRESENT | packed pair valid on m_a/m_b, waiting for m_ready
// DROP    | discarding beats until one carries s_last
module matrix_loader #(
  parameter int DW = 4,
  parameter int N  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [N*N*DW-1:0] m_a,
  output logic [N*N*DW-1:0] m_b,
  output logic              err
);

  localparam int NE = N * N;
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;
  localparam int MW = NE * DW;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2,
    DROP    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [MW-1:0]   a_buf_q, a_buf_d;
  logic [MW-1:0]   b_buf_q, b_buf_d;
  logic [MW-1:0]   m_a_q, m_a_d;
  logic [MW-1:0]   m_b_q, m_b_d;
  logic            err_q, err_d;

  logic            accept;
  logic            idx_last;
  int              slot_lsb;

  assign accept   = s_valid && s_ready;
  assign idx_last = (idx_q == IW'(NE - 1));
  // Element (0,0) sits in the most significant lane, so slot idx maps downward.
  assign slot_lsb = (NE - 1 - int'(idx_q)) * DW;

  // State register and datapath flops, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
      a_buf_q <= '0;
      b_buf_q <= '0;
      m_a_q   <= '0;
      m_b_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_buf_q <= a_buf_d;
      b_buf_q <= b_buf_d;
      m_a_q   <= m_a_d;
      m_b_q   <= m_b_d;
      err_q   <= err_d;
    end
  end

  // Next-state, element storage and framing-error detection.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_buf_d = a_buf_q;
    b_buf_d = b_buf_q;
    m_a_d   = m_a_q;
    m_b_d   = m_b_q;
    err_d   = 1'b0;
    case (state_q)
      LOAD_A: begin
        if (accept) begin
          a_buf_d[slot_lsb +: DW] = s_data;
          if (s_last) begin
            err_d   = 1'b1;
            state_d = LOAD_A;
            idx_d   = '0;
          end else if (idx_last) begin
            state_d = LOAD_B;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      LOAD_B: begin
        if (accept) begin
          b_buf_d[slot_lsb +: DW] = s_data;
          if (idx_last) begin
            idx_d = '0;
            if (s_last) begin
              // Outputs are only loaded here, so they hold across consumption.
              state_d = PRESENT;
              m_a_d   = a_buf_q;
              m_b_d   = b_buf_d;
            end else begin
              err_d   = 1'b1;
              state_d = DROP;
            end
          end else if (s_last) begin
            err_d   = 1'b1;
            state_d = LOAD_A;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      PRESENT: begin
        if (m_ready) begin
          state_d = LOAD_A;
          idx_d   = '0;
        end
      end
      DROP: begin
        if (accept && s_last) begin
          state_d = LOAD_A;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = LOAD_A;
        idx_d   = '0;
      end
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    s_ready = rst_n && (state_q != PRESENT);
    m_valid = (state_q == PRESENT);
  end

  assign m_a = m_a_q;
  assign m_b = m_b_q;
  assign err = err_q;

endmodule
